// File: rtl/vga_pkg.sv
// Shared mode encoding, 12-bit RGB colour constants and raster timing helpers
// for the VGA pixel pipeline.
package vga_pkg;

  typedef enum logic [1:0] {
    MODE_SOLID  = 2'd0,
    MODE_BANDS  = 2'd1,
    MODE_MANUAL = 2'd2,
    MODE_BOUNCE = 2'd3
  } mode_e;

  localparam logic [11:0] BLUE   = 12'h00F;
  localparam logic [11:0] ORANGE = 12'hFC0;
  localparam logic [11:0] RED    = 12'hF00;
  localparam logic [11:0] BAR    = 12'h68D;
  localparam logic [11:0] WHITE  = 12'hFFF;
  localparam logic [11:0] SOLID  = 12'hF3C;

  function automatic int line_total(input int active, input int fp, input int sync, input int bp);
    return active + fp + sync + bp;
  endfunction

endpackage

// File: rtl/vga_raster_timing.sv
// Stage-0 raster counters with sync windows, active-area flag and the
// combinational pre-pulse that marks the first vblank pixel.
module vga_raster_timing
  import vga_pkg::*;
#(
  parameter int H_ACTIVE = 1920,
  parameter int H_FP     = 88,
  parameter int H_SYNC   = 44,
  parameter int H_BP     = 148,
  parameter int V_ACTIVE = 1080,
  parameter int V_FP     = 4,
  parameter int V_SYNC   = 5,
  parameter int V_BP     = 36,
  parameter int CW       = 12
) (
  input  logic          clk_148MHz,
  input  logic          reset_n,
  output logic [CW-1:0] hc,
  output logic [CW-1:0] vc,
  output logic          h_sync_win,
  output logic          v_sync_win,
  output logic          active,
  output logic          tick_pre
);

  localparam int H_TOTAL = line_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
  localparam int V_TOTAL = line_total(V_ACTIVE, V_FP, V_SYNC, V_BP);

  localparam logic [CW-1:0] H_LAST = CW'(H_TOTAL - 1);
  localparam logic [CW-1:0] V_LAST = CW'(V_TOTAL - 1);
  localparam logic [CW-1:0] H_ACT  = CW'(H_ACTIVE);
  localparam logic [CW-1:0] V_ACT  = CW'(V_ACTIVE);
  localparam logic [CW-1:0] HS_BEG = CW'(H_ACTIVE + H_FP);
  localparam logic [CW-1:0] HS_END = CW'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam logic [CW-1:0] VS_BEG = CW'(V_ACTIVE + V_FP);
  localparam logic [CW-1:0] VS_END = CW'(V_ACTIVE + V_FP + V_SYNC - 1);

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk_148MHz or negedge reset_n) begin
    if (!reset_n) begin
      hc <= '0;
      vc <= '0;
    end else if (hc == H_LAST) begin
      hc <= '0;
      vc <= (vc == V_LAST) ? '0 : vc + CW'(1);
    end else begin
      hc <= hc + CW'(1);
    end
  end

  always_comb begin
    h_sync_win = (hc >= HS_BEG) && (hc <= HS_END);
    v_sync_win = (vc >= VS_BEG) && (vc <= VS_END);
    active     = (hc < H_ACT) && (vc < V_ACT);
    tick_pre   = (hc == '0) && (vc == V_ACT);
  end

endmodule

// File: rtl/vga_sprite_engine.sv
// Raster-timed renderer for a tri-colour circular sprite over a gap-bar obstacle;
// sprite moves by buttons or auto-bounce, committing only at vblank start.
module vga_sprite_engine
  import vga_pkg::*;
#(
  parameter int H_ACTIVE        = 1920,
  parameter int H_FP            = 88,
  parameter int H_SYNC          = 44,
  parameter int H_BP            = 148,
  parameter int V_ACTIVE        = 1080,
  parameter int V_FP            = 4,
  parameter int V_SYNC          = 5,
  parameter int V_BP            = 36,
  parameter bit HSYNC_POL       = 1'b1,
  parameter bit VSYNC_POL       = 1'b1,
  parameter int CW              = 12,
  parameter int RADIUS          = 100,
  parameter int STEP            = 2,
  parameter int FRAMES_PER_STEP = 1,
  parameter int BAR_X0          = 1400,
  parameter int BAR_W           = 200,
  parameter int GAP_Y0          = 600,
  parameter int GAP_Y1          = 850
) (
  input  logic          clk_148MHz,
  input  logic          reset_n,
  input  logic [1:0]    mode,
  input  logic          btnU,
  input  logic          btnD,
  input  logic          btnL,
  input  logic          btnR,
  output logic          hsync,
  output logic          vsync,
  output logic          video_on,
  output logic [CW-1:0] h_count,
  output logic [CW-1:0] v_count,
  output logic [3:0]    vgaRed,
  output logic [3:0]    vgaGreen,
  output logic [3:0]    vgaBlue,
  output logic          frame_tick
);

  localparam int PW    = CW + 2;
  localparam int SW    = 2 * CW + 2;
  localparam int DIV_W = $clog2(FRAMES_PER_STEP + 1);

  typedef logic signed [PW-1:0] pos_t;

  localparam pos_t P_R    = pos_t'(RADIUS);
  localparam pos_t P_STEP = pos_t'(STEP);
  localparam pos_t X_MAX  = pos_t'(H_ACTIVE - 1 - RADIUS);
  localparam pos_t Y_MAX  = pos_t'(V_ACTIVE - 1 - RADIUS);
  localparam pos_t X_HOME = pos_t'(H_ACTIVE / 2);
  localparam pos_t Y_HOME = pos_t'(V_ACTIVE / 2);
  localparam pos_t BAR_L  = pos_t'(BAR_X0);
  localparam pos_t BAR_R  = pos_t'(BAR_X0 + BAR_W - 1);
  localparam pos_t GAP_T  = pos_t'(GAP_Y0);
  localparam pos_t GAP_B  = pos_t'(GAP_Y1);
  localparam pos_t SEG1   = pos_t'((2 * RADIUS) / 3);
  localparam pos_t SEG2   = pos_t'((4 * RADIUS) / 3);

  localparam logic signed [SW-1:0] R_SQ     = SW'(RADIUS * RADIUS);
  localparam logic [CW-1:0]        THIRD1   = CW'(H_ACTIVE / 3);
  localparam logic [CW-1:0]        THIRD2   = CW'((2 * H_ACTIVE) / 3);
  localparam logic [DIV_W-1:0]     DIV_LAST = DIV_W'(FRAMES_PER_STEP - 1);

  logic [CW-1:0] hc, vc;
  logic          hs_win, vs_win, active, tick_pre;

  vga_raster_timing #(
    .H_ACTIVE(H_ACTIVE), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
    .V_ACTIVE(V_ACTIVE), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP),
    .CW(CW)
  ) u_timing (
    .clk_148MHz(clk_148MHz),
    .reset_n   (reset_n),
    .hc        (hc),
    .vc        (vc),
    .h_sync_win(hs_win),
    .v_sync_win(vs_win),
    .active    (active),
    .tick_pre  (tick_pre)
  );

  mode_e cur_mode;
  assign cur_mode = mode_e'(mode);

  // Buttons packed {U, D, L, R}.
  logic [3:0] btn_meta, btn_sync;
  always_ff @(posedge clk_148MHz or negedge reset_n) begin
    if (!reset_n) begin
      btn_meta <= '0;
      btn_sync <= '0;
    end else begin
      btn_meta <= {btnU, btnD, btnL, btnR};
      btn_sync <= btn_meta;
    end
  end

  pos_t             cx, cy, nx, ny, nx_c, ny_c;
  logic             vx_neg, vy_neg;
  logic [DIV_W-1:0] div;
  logic             hit_xl, hit_xh, hit_yl, hit_yh, bar_hit;

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    nx = cx;
    ny = cy;
    if (cur_mode == MODE_BOUNCE) begin
      nx = vx_neg ? cx - P_STEP : cx + P_STEP;
      ny = vy_neg ? cy - P_STEP : cy + P_STEP;
    end else begin
      if (btn_sync[0] && !btn_sync[1]) nx = cx + P_STEP;
      else if (btn_sync[1] && !btn_sync[0]) nx = cx - P_STEP;
      if (btn_sync[2] && !btn_sync[3]) ny = cy + P_STEP;
      else if (btn_sync[3] && !btn_sync[2]) ny = cy - P_STEP;
    end
    // Touching an edge counts as a hit; the clamp is the identity there.
    hit_xl  = nx <= P_R;
    hit_xh  = nx >= X_MAX;
    hit_yl  = ny <= P_R;
    hit_yh  = ny >= Y_MAX;
    nx_c    = hit_xl ? P_R : (hit_xh ? X_MAX : nx);
    ny_c    = hit_yl ? P_R : (hit_yh ? Y_MAX : ny);
    bar_hit = (nx_c + P_R >= BAR_L) && (nx_c - P_R <= BAR_R) &&
              ((ny_c - P_R <= GAP_T) || (ny_c + P_R >= GAP_B));
  end

  always_ff @(posedge clk_148MHz or negedge reset_n) begin
    if (!reset_n) begin
      cx     <= X_HOME;
      cy     <= Y_HOME;
      vx_neg <= 1'b0;
      vy_neg <= 1'b0;
      div    <= '0;
    end else if (frame_tick) begin
      div <= (div == DIV_LAST) ? '0 : div + DIV_W'(1);
      if (div == DIV_LAST) begin
        case (cur_mode)
          MODE_MANUAL: begin
            cx <= bar_hit ? X_HOME : nx_c;
            cy <= bar_hit ? Y_HOME : ny_c;
          end
          MODE_BOUNCE: begin
            if (bar_hit) begin
              vx_neg <= ~vx_neg;
            end else begin
              cx <= nx_c;
              cy <= ny_c;
              if (hit_xl) vx_neg <= 1'b0;
              else if (hit_xh) vx_neg <= 1'b1;
              if (hit_yl) vy_neg <= 1'b0;
              else if (hit_yh) vy_neg <= 1'b1;
            end
          end
          default: ;
        endcase
      end
    end
  end

  logic signed [CW:0]   dx, dy;
  logic signed [SW-1:0] dx_w, dy_w, dist_sq;
  pos_t                 rel, hx, vy;
  logic                 in_circle, on_bar;
  logic [11:0]          rgb_d;

  always_comb begin
    dx        = $signed({1'b0, hc}) - cx[CW:0];
    dy        = $signed({1'b0, vc}) - cy[CW:0];
    dx_w      = {{(SW-CW-1){dx[CW]}}, dx};
    dy_w      = {{(SW-CW-1){dy[CW]}}, dy};
    dist_sq   = dx_w * dx_w + dy_w * dy_w;
    in_circle = dist_sq <= R_SQ;
    rel       = $signed({dx[CW], dx}) + P_R;
    hx        = $signed({2'b00, hc});
    vy        = $signed({2'b00, vc});
    on_bar    = (hx >= BAR_L) && (hx <= BAR_R) && ((vy <= GAP_T) || (vy >= GAP_B));
    rgb_d     = '0;
    if (active) begin
      case (cur_mode)
        MODE_SOLID: rgb_d = SOLID;
        MODE_BANDS: rgb_d = (hc < THIRD1) ? BLUE : ((hc < THIRD2) ? ORANGE : RED);
        default: begin
          if (in_circle) rgb_d = (rel < SEG1) ? BLUE : ((rel < SEG2) ? ORANGE : RED);
          else if (on_bar) rgb_d = BAR;
          else rgb_d = WHITE;
        end
      endcase
    end
  end

  // Stage 1: every pin-facing output comes from this one register rank.
  always_ff @(posedge clk_148MHz or negedge reset_n) begin
    if (!reset_n) begin
      hsync                      <= ~HSYNC_POL;
      vsync                      <= ~VSYNC_POL;
      video_on                   <= 1'b0;
      h_count                    <= '0;
      v_count                    <= '0;
      {vgaRed, vgaGreen, vgaBlue} <= '0;
      frame_tick                 <= 1'b0;
    end else begin
      hsync                      <= hs_win ? HSYNC_POL : ~HSYNC_POL;
      vsync                      <= vs_win ? VSYNC_POL : ~VSYNC_POL;
      video_on                   <= active;
      h_count                    <= hc;
      v_count                    <= vc;
      {vgaRed, vgaGreen, vgaBlue} <= rgb_d;
      frame_tick                 <= tick_pre;
    end
  end

endmodule

// File: tb/tb_vga_sprite_engine.sv
// Directed bench: small-timing sync/frame checks, 1080p band table, and
// scaled-down sprite instances for manual stepping and bounce clamping.
module tb_vga_sprite_engine;
  import vga_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input longint act, input longint exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  // Instance A: tiny timing, active-low hsync, solid colour.
  logic        a_rst_n = 1'b0;
  logic [1:0]  a_mode = 2'd0;
  logic        a_hs, a_vs, a_vo, a_ft;
  logic [11:0] a_hc, a_vc;
  logic [3:0]  a_r, a_g, a_b;

  vga_sprite_engine #(
    .H_ACTIVE(16), .H_FP(2), .H_SYNC(3), .H_BP(2),
    .V_ACTIVE(8), .V_FP(1), .V_SYNC(2), .V_BP(1),
    .HSYNC_POL(1'b0)
  ) dut_a (
    .clk_148MHz(clk), .reset_n(a_rst_n), .mode(a_mode),
    .btnU(1'b0), .btnD(1'b0), .btnL(1'b0), .btnR(1'b0),
    .hsync(a_hs), .vsync(a_vs), .video_on(a_vo), .h_count(a_hc), .v_count(a_vc),
    .vgaRed(a_r), .vgaGreen(a_g), .vgaBlue(a_b), .frame_tick(a_ft)
  );

  // Instance B: default 1080p timing, band mode.
  logic        b_rst_n = 1'b0;
  logic [1:0]  b_mode = 2'd1;
  logic        b_hs, b_vs, b_vo, b_ft;
  logic [11:0] b_hc, b_vc;
  logic [3:0]  b_r, b_g, b_b;

  vga_sprite_engine dut_b (
    .clk_148MHz(clk), .reset_n(b_rst_n), .mode(b_mode),
    .btnU(1'b0), .btnD(1'b0), .btnL(1'b0), .btnR(1'b0),
    .hsync(b_hs), .vsync(b_vs), .video_on(b_vo), .h_count(b_hc), .v_count(b_vc),
    .vgaRed(b_r), .vgaGreen(b_g), .vgaBlue(b_b), .frame_tick(b_ft)
  );

  // Instance C: scaled sprite scene, manual mode.
  logic        c_rst_n = 1'b0;
  logic [1:0]  c_mode = 2'd2;
  logic        c_u = 1'b0, c_d = 1'b0, c_l = 1'b0, c_rb = 1'b0;
  logic        c_hs, c_vs, c_vo, c_ft;
  logic [11:0] c_hc, c_vc;
  logic [3:0]  c_r, c_g, c_b;

  vga_sprite_engine #(
    .H_ACTIVE(80), .H_FP(2), .H_SYNC(3), .H_BP(2),
    .V_ACTIVE(48), .V_FP(1), .V_SYNC(2), .V_BP(1),
    .RADIUS(6), .STEP(2), .BAR_X0(60), .BAR_W(8), .GAP_Y0(20), .GAP_Y1(40)
  ) dut_c (
    .clk_148MHz(clk), .reset_n(c_rst_n), .mode(c_mode),
    .btnU(c_u), .btnD(c_d), .btnL(c_l), .btnR(c_rb),
    .hsync(c_hs), .vsync(c_vs), .video_on(c_vo), .h_count(c_hc), .v_count(c_vc),
    .vgaRed(c_r), .vgaGreen(c_g), .vgaBlue(c_b), .frame_tick(c_ft)
  );

  // Instance D: narrow screen, large radius, bounce mode with the bar off-screen.
  logic        d_rst_n = 1'b0;
  logic [1:0]  d_mode = 2'd3;
  logic        d_hs, d_vs, d_vo, d_ft;
  logic [11:0] d_hc, d_vc;
  logic [3:0]  d_r, d_g, d_b;

  vga_sprite_engine #(
    .H_ACTIVE(40), .H_FP(2), .H_SYNC(3), .H_BP(2),
    .V_ACTIVE(60), .V_FP(1), .V_SYNC(2), .V_BP(1),
    .RADIUS(17), .STEP(2), .BAR_X0(200), .BAR_W(8), .GAP_Y0(0), .GAP_Y1(59)
  ) dut_d (
    .clk_148MHz(clk), .reset_n(d_rst_n), .mode(d_mode),
    .btnU(1'b1), .btnD(1'b0), .btnL(1'b0), .btnR(1'b1),
    .hsync(d_hs), .vsync(d_vs), .video_on(d_vo), .h_count(d_hc), .v_count(d_vc),
    .vgaRed(d_r), .vgaGreen(d_g), .vgaBlue(d_b), .frame_tick(d_ft)
  );

  typedef struct {
    int          h;
    logic        vo;
    logic        hs;
    logic [11:0] rgb;
  } vec_t;

  vec_t vecs[11];

  // Cycles from reset release until instance A shows frame_tick.
  task automatic a_first_tick(input string tag);
    int cnt = 0;
    bit ok  = 1'b0;
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk);
      cnt++;
      if (a_ft) begin
        ok = 1'b1;
        break;
      end
    end
    check({tag, "_seen"}, ok, 1);
    check({tag, "_cycles"}, cnt, 185);
    check({tag, "_hc"}, a_hc, 0);
    check({tag, "_vc"}, a_vc, 8);
  endtask

  task automatic c_pix(input int h, input int v, input logic [11:0] exp, input string tag);
    bit ok = 1'b0;
    for (int i = 0; i < 6000; i++) begin
      @(negedge clk);
      if (c_hc == 12'(h) && c_vc == 12'(v)) begin
        ok = 1'b1;
        break;
      end
    end
    check({tag, "_reached"}, ok, 1);
    check(tag, {c_r, c_g, c_b}, exp);
  endtask

  task automatic c_step(input int old_x, input int new_x, input int new_y, input string tag);
    bit ok = 1'b0;
    for (int i = 0; i < 6000; i++) begin
      @(negedge clk);
      if (c_ft) begin
        ok = 1'b1;
        break;
      end
    end
    check({tag, "_tick"}, ok, 1);
    check({tag, "_hold"}, dut_c.cx, old_x);
    @(negedge clk);
    check({tag, "_x"}, dut_c.cx, new_x);
    check({tag, "_y"}, dut_c.cy, new_y);
  endtask

  task automatic d_step(input int old_x, input int new_x, input int new_y, input string tag);
    bit ok = 1'b0;
    for (int i = 0; i < 4000; i++) begin
      @(negedge clk);
      if (d_ft) begin
        ok = 1'b1;
        break;
      end
    end
    check({tag, "_tick"}, ok, 1);
    check({tag, "_hold"}, dut_d.cx, old_x);
    @(negedge clk);
    check({tag, "_x"}, dut_d.cx, new_x);
    check({tag, "_y"}, dut_d.cy, new_y);
    check({tag, "_vxneg"}, dut_d.vx_neg, 1);
  endtask

  initial begin
    int cnt, hs_low, hs_min, hs_max, vs_hi, vs_min, vs_max, vo_cnt, bad_rgb;
    bit ok;

    vecs[0]  = '{0,    1'b1, 1'b0, BLUE};
    vecs[1]  = '{639,  1'b1, 1'b0, BLUE};
    vecs[2]  = '{640,  1'b1, 1'b0, ORANGE};
    vecs[3]  = '{1279, 1'b1, 1'b0, ORANGE};
    vecs[4]  = '{1280, 1'b1, 1'b0, RED};
    vecs[5]  = '{1919, 1'b1, 1'b0, RED};
    vecs[6]  = '{1920, 1'b0, 1'b0, 12'h000};
    vecs[7]  = '{2007, 1'b0, 1'b0, 12'h000};
    vecs[8]  = '{2008, 1'b0, 1'b1, 12'h000};
    vecs[9]  = '{2051, 1'b0, 1'b1, 12'h000};
    vecs[10] = '{2052, 1'b0, 1'b0, 12'h000};

    // ---- A: reset values ----
    repeat (3) @(negedge clk);
    check("a_rst_hsync", a_hs, 1);
    check("a_rst_vsync", a_vs, 0);
    check("a_rst_video_on", a_vo, 0);
    check("a_rst_rgb", {a_r, a_g, a_b}, 0);
    check("a_rst_frame_tick", a_ft, 0);
    check("a_rst_h_count", a_hc, 0);
    check("a_rst_v_count", a_vc, 0);

    a_rst_n = 1'b1;
    a_first_tick("a_first");

    // ---- A: one full frame between ticks ----
    cnt = 0; hs_low = 0; hs_min = 999; hs_max = -1;
    vs_hi = 0; vs_min = 999; vs_max = -1; vo_cnt = 0; bad_rgb = 0; ok = 1'b0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      cnt++;
      if (!a_hs) begin
        hs_low++;
        if (int'(a_hc) < hs_min) hs_min = int'(a_hc);
        if (int'(a_hc) > hs_max) hs_max = int'(a_hc);
      end
      if (a_vs) begin
        vs_hi++;
        if (int'(a_vc) < vs_min) vs_min = int'(a_vc);
        if (int'(a_vc) > vs_max) vs_max = int'(a_vc);
      end
      if (a_vo) vo_cnt++;
      if ({a_r, a_g, a_b} !== (a_vo ? SOLID : 12'h000)) bad_rgb++;
      if (a_ft) begin
        ok = 1'b1;
        break;
      end
    end
    check("a_period_seen", ok, 1);
    check("a_frame_period", cnt, 276);
    check("a_hsync_low_cycles", hs_low, 36);
    check("a_hsync_first_hc", hs_min, 18);
    check("a_hsync_last_hc", hs_max, 20);
    check("a_vsync_high_cycles", vs_hi, 46);
    check("a_vsync_first_vc", vs_min, 9);
    check("a_vsync_last_vc", vs_max, 10);
    check("a_active_cycles", vo_cnt, 128);
    check("a_solid_rgb_errors", bad_rgb, 0);

    // ---- A: asynchronous reset mid-line ----
    ok = 1'b0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (a_hc == 12'd10 && a_vc == 12'd2) begin
        ok = 1'b1;
        break;
      end
    end
    check("a_midline_reached", ok, 1);
    check("a_midline_active", a_vo, 1);
    a_rst_n = 1'b0;
    #1;
    check("a_async_h_count", a_hc, 0);
    check("a_async_v_count", a_vc, 0);
    check("a_async_hsync", a_hs, 1);
    check("a_async_video_on", a_vo, 0);
    check("a_async_rgb", {a_r, a_g, a_b}, 0);
    @(negedge clk);
    a_rst_n = 1'b1;
    a_first_tick("a_rerelease");

    // ---- B: 1080p band colours and hsync edges, table-driven ----
    b_rst_n = 1'b1;
    foreach (vecs[k]) begin
      ok = 1'b0;
      for (int i = 0; i < 3000; i++) begin
        @(negedge clk);
        if (b_hc == 12'(vecs[k].h)) begin
          ok = 1'b1;
          break;
        end
      end
      check($sformatf("b_reach_h%0d", vecs[k].h), ok, 1);
      check($sformatf("b_px_h%0d", vecs[k].h), {b_vo, b_hs, b_r, b_g, b_b},
            {vecs[k].vo, vecs[k].hs, vecs[k].rgb});
    end
    b_rst_n = 1'b0;

    // ---- C: sprite/bar rendering in frame 0, centre (40,24) ----
    c_rst_n = 1'b1;
    c_pix(62, 10, BAR,    "c_bar_top");
    c_pix(40, 17, WHITE,  "c_above_radius");
    c_pix(40, 18, ORANGE, "c_on_radius");
    c_pix(35, 24, BLUE,   "c_left_seg");
    c_pix(40, 24, ORANGE, "c_mid_seg");
    c_pix(45, 24, RED,    "c_right_seg");
    c_pix(47, 24, WHITE,  "c_outside");
    c_pix(62, 24, WHITE,  "c_gap");
    c_pix(62, 40, BAR,    "c_bar_bottom");

    // ---- C: manual stepping ----
    c_rb = 1'b1;
    c_step(40, 42, 24, "c_r1");
    c_step(42, 44, 24, "c_r2");
    c_step(44, 46, 24, "c_r3");
    c_l = 1'b1;
    c_step(46, 46, 24, "c_lr");
    c_l = 1'b0;
    c_step(46, 48, 24, "c_r4");
    c_step(48, 50, 24, "c_r5");
    c_step(50, 52, 24, "c_r6");
    c_step(52, 40, 24, "c_bar_reset");
    c_rb = 1'b0;
    c_rst_n = 1'b0;

    // ---- D: bounce off the right edge, buttons ignored ----
    d_rst_n = 1'b1;
    d_step(20, 22, 32, "d_clamp");
    d_step(22, 20, 34, "d_return");
    d_rst_n = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
